// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types, defaults and address-field widths for the data cache.
// Revision : 1.0
// ============================================================================
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  localparam int c_def_lines = 16;
  localparam int c_def_words = 4;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

  // Byte-address bits left above index, offset and the two byte-lane bits.
  function automatic int tag_width(input int lines, input int words);
    return 32 - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Brief    : LINES x WORDS x 32 data store, one write port, combinational read.
// Revision : 1.0
// ============================================================================
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = c_def_lines,
  parameter int WORDS = c_def_words
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] widx,
  input  logic [$clog2(WORDS)-1:0] woff,
  input  logic [31:0]              wdata,
  input  logic [$clog2(LINES)-1:0] ridx,
  input  logic [$clog2(WORDS)-1:0] roff,
  output logic [31:0]              rdata
);

  localparam int c_aw    = $clog2(LINES) + $clog2(WORDS);
  localparam int c_depth = LINES * WORDS;

  logic [31:0]     r_mem [c_depth];
  logic [c_aw-1:0] w_waddr;
  logic [c_aw-1:0] w_raddr;

  assign w_waddr = {widx, woff};
  assign w_raddr = {ridx, roff};

  // Contents are deliberately left uninitialised; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_waddr] <= wdata;
    end
  end

  assign rdata = r_mem[w_raddr];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped write-back data cache controller with word-serial
//            DRAM writeback/fill and a combinational stall request.
// Revision : 1.0
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = c_def_lines,
  parameter int WORDS = c_def_words
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_ce,
  input  logic        mem_write_ce,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dram_cache_miss,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata
);

  localparam int c_iw = idx_width(LINES);
  localparam int c_ow = off_width(WORDS);
  localparam int c_tw = tag_width(LINES, WORDS);
  localparam logic [c_ow-1:0] c_last = c_ow'(WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_ow-1:0]  r_cnt;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [c_tw-1:0]  r_tag [LINES];
  logic [c_iw-1:0]  r_idx;
  logic [c_tw-1:0]  r_new_tag;

  logic [c_ow-1:0]  w_off;
  logic [c_iw-1:0]  w_idx;
  logic [c_tw-1:0]  w_tag;
  logic             w_unused_lanes;
  logic             w_access;
  logic             w_idle;
  logic             w_hit;
  logic             w_store_hit;
  logic             w_miss_start;
  logic             w_last;
  logic             w_wb_ack;
  logic             w_fill_ack;

  logic             w_arr_we;
  logic [c_iw-1:0]  w_arr_idx;
  logic [c_ow-1:0]  w_arr_off;
  logic [31:0]      w_arr_wdata;
  logic [31:0]      w_arr_rdata;

  assign w_off          = addr[c_ow+1:2];
  assign w_idx          = addr[c_ow+c_iw+1:c_ow+2];
  assign w_tag          = addr[31:c_ow+c_iw+2];
  assign w_unused_lanes = &{1'b0, addr[1:0]};

  // Both enables high is the stall unit's crash case: treated as no access.
  assign w_access     = mem_read_ce ^ mem_write_ce;
  assign w_idle       = (r_state == ST_IDLE);
  assign w_hit        = w_access && w_idle && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_store_hit  = w_hit && mem_write_ce;
  assign w_miss_start = w_access && w_idle && !w_hit;
  assign w_last       = (r_cnt == c_last);
  assign w_wb_ack     = (r_state == ST_WB) && dram_ack;
  assign w_fill_ack   = (r_state == ST_FILL) && dram_ack;

  // The one array port is owned by the MEM stage in IDLE and by the line
  // transfer otherwise, so a single idx/offset mux serves read and write.
  assign w_arr_we    = w_store_hit || w_fill_ack;
  assign w_arr_idx   = w_idle ? w_idx : r_idx;
  assign w_arr_off   = w_idle ? w_off : r_cnt;
  assign w_arr_wdata = w_idle ? wdata : dram_rdata;

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .widx  (w_arr_idx),
    .woff  (w_arr_off),
    .wdata (w_arr_wdata),
    .ridx  (w_arr_idx),
    .roff  (w_arr_off),
    .rdata (w_arr_rdata)
  );

  assign rdata           = (w_hit && mem_read_ce) ? w_arr_rdata : 32'd0;
  assign dram_cache_miss = !rst && (!w_idle || (w_access && !w_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dram_req    = 1'b0;
    dram_we     = 1'b0;
    dram_addr   = 32'd0;
    dram_wdata  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss_start) begin
          w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        dram_req   = 1'b1;
        dram_we    = 1'b1;
        dram_addr  = {r_tag[r_idx], r_idx, r_cnt, 2'b00};
        dram_wdata = w_arr_rdata;
        if (dram_ack && w_last) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        dram_req  = 1'b1;
        dram_addr = {r_new_tag, r_idx, r_cnt, 2'b00};
        if (dram_ack && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_idx     <= '0;
      r_new_tag <= '0;
    end else begin
      if (w_miss_start) begin
        r_idx     <= w_idx;
        r_new_tag <= w_tag;
      end
      if (w_store_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_wb_ack || w_fill_ack) begin
        if (w_last) begin
          r_cnt          <= '0;
          r_dirty[r_idx] <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_fill_ack && w_last) begin
        r_valid[r_idx] <= 1'b1;
      end
    end
  end

  // Tags need no reset: an invalid line's tag is never consulted.
  always_ff @(posedge clk) begin
    if (w_fill_ack && w_last) begin
      r_tag[r_idx] <= r_new_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Self-checking bench for dcache_ctrl against a line-level cache model.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_ce, mem_write_ce;
  logic [31:0] addr, wdata, rdata;
  logic        dram_cache_miss, dram_req, dram_we, dram_ack;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_ce     (mem_read_ce),
    .mem_write_ce    (mem_write_ce),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .dram_cache_miss (dram_cache_miss),
    .dram_req        (dram_req),
    .dram_we         (dram_we),
    .dram_addr       (dram_addr),
    .dram_wdata      (dram_wdata),
    .dram_ack        (dram_ack),
    .dram_rdata      (dram_rdata)
  );

  // External DRAM contents; untouched words follow a fixed pattern.
  logic [31:0] dram_mem [logic [31:0]];

  function automatic logic [31:0] dram_word(input logic [31:0] a);
    if (dram_mem.exists(a)) return dram_mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Reference cache: per-line state and data, computed from address fields.
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];

  logic [31:0] e_addr[$];
  bit          e_we[$];
  logic [31:0] e_wdata[$];
  logic [31:0] e_rdata;
  bit          e_miss;

  logic [31:0] q_addr[$];
  bit          q_we[$];
  logic [31:0] q_wdata[$];
  logic [31:0] obs_rdata;
  int          obs_stall;
  int          obs_unstable;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic predict(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int          idx, off;
    logic [31:0] tg;
    e_addr.delete(); e_we.delete(); e_wdata.delete();
    e_rdata = 32'd0;
    e_miss  = 0;
    if (rd == wr) return;
    idx = int'((a >> 4) % LINES);
    off = int'((a >> 2) % WORDS);
    tg  = a >> 8;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      e_miss = 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < WORDS; w++) begin
          e_addr.push_back((m_tag[idx] << 8) | 32'(idx << 4) | 32'(w << 2));
          e_we.push_back(1);
          e_wdata.push_back(m_data[idx][w]);
        end
      end
      for (int w = 0; w < WORDS; w++) begin
        e_addr.push_back((tg << 8) | 32'(idx << 4) | 32'(w << 2));
        e_we.push_back(0);
        e_wdata.push_back(32'd0);
        m_data[idx][w] = dram_word((tg << 8) | 32'(idx << 4) | 32'(w << 2));
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
    end
    if (rd) begin
      e_rdata = m_data[idx][off];
    end else begin
      m_data[idx][off] = wd;
      m_dirty[idx]     = 1;
    end
  endtask

  // Drives one MEM-stage access and plays DRAM, acking each word after
  // 'delay' waiting cycles. Records every acked word and the stall length.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int delay);
    int          waitc;
    bit          done, preq, pack, pwe;
    logic [31:0] pa, pw;
    q_addr.delete(); q_we.delete(); q_wdata.delete();
    obs_stall = 0; obs_unstable = 0; obs_rdata = 32'd0;
    waitc = 0; done = 0; preq = 0; pack = 0; pwe = 0; pa = 32'd0; pw = 32'd0;
    @(negedge clk);
    mem_read_ce = rd; mem_write_ce = wr; addr = a; wdata = wd; dram_ack = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      #1;
      if (!dram_cache_miss) begin
        obs_rdata = rdata;
        done      = 1;
      end else begin
        obs_stall++;
        if (dram_req) begin
          if (preq && !pack && (dram_addr !== pa || dram_wdata !== pw || dram_we !== pwe))
            obs_unstable++;
          pa = dram_addr; pw = dram_wdata; pwe = dram_we;
          if (waitc == delay) begin
            q_addr.push_back(dram_addr);
            q_we.push_back(dram_we);
            q_wdata.push_back(dram_wdata);
            if (dram_we) dram_mem[dram_addr] = dram_wdata;
            else         dram_rdata = dram_word(dram_addr);
            dram_ack = 1'b1;
            waitc    = 0;
            pack     = 1;
          end else begin
            waitc++;
            pack = 0;
          end
        end else begin
          pack = 0;
        end
        preq = dram_req;
        @(negedge clk);
        dram_ack = 1'b0;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL access_timeout addr=%h: stall still high after 2000 cycles, required to complete", a);
    end
    @(negedge clk);
    mem_read_ce = 1'b0; mem_write_ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read_ce = 1'b0; mem_write_ce = 1'b0; addr = 32'd0; wdata = 32'd0;
    dram_ack = 1'b0; dram_rdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    mem_read_ce = 1'b1; addr = 32'h100;
    #1;
    compared++; if (dram_cache_miss !== 1'b0) begin mismatched++; $display("FAIL reset_miss got %b want 0", dram_cache_miss); end
    compared++; if (dram_req !== 1'b0)        begin mismatched++; $display("FAIL reset_req got %b want 0", dram_req); end
    compared++; if (dram_we !== 1'b0)         begin mismatched++; $display("FAIL reset_we got %b want 0", dram_we); end
    compared++; if (dram_addr !== 32'd0)      begin mismatched++; $display("FAIL reset_dram_addr got %h want 0", dram_addr); end
    compared++; if (dram_wdata !== 32'd0)     begin mismatched++; $display("FAIL reset_dram_wdata got %h want 0", dram_wdata); end
    compared++; if (rdata !== 32'd0)          begin mismatched++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk);
    mem_read_ce = 1'b0; rst = 1'b0;
  endtask

  task automatic test_clean_fill();
    for (int i = 0; i < WORDS; i++) dram_mem[32'h100 + 32'(4 * i)] = 32'hA0A0_0000 + 32'(i);
    predict(1, 0, 32'h100, 32'd0);
    run_access(1, 0, 32'h100, 32'd0, 0);
    compared++;
    if (q_addr.size() != WORDS) begin
      mismatched++; $display("FAIL clean_fill_words got %0d want %0d", q_addr.size(), WORDS);
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        compared++;
        if (q_addr[i] !== 32'h100 + 32'(4 * i) || q_we[i] !== 1'b0) begin
          mismatched++; $display("FAIL clean_fill_addr[%0d] got %h we=%b want %h we=0", i, q_addr[i], q_we[i], 32'h100 + 32'(4 * i));
        end
      end
    end
    compared++; if (obs_rdata !== 32'hA0A0_0000) begin mismatched++; $display("FAIL clean_fill_rdata got %h want a0a00000", obs_rdata); end
    compared++; if (obs_stall != WORDS + 1) begin mismatched++; $display("FAIL clean_fill_stall got %0d want %0d", obs_stall, WORDS + 1); end
  endtask

  task automatic test_store_hit();
    predict(0, 1, 32'h104, 32'hDEAD_BEEF);
    run_access(0, 1, 32'h104, 32'hDEAD_BEEF, 0);
    compared++; if (obs_stall != 0) begin mismatched++; $display("FAIL store_hit_stall got %0d want 0", obs_stall); end
    predict(1, 0, 32'h104, 32'd0);
    run_access(1, 0, 32'h104, 32'd0, 0);
    compared++; if (obs_stall != 0) begin mismatched++; $display("FAIL load_hit_stall got %0d want 0", obs_stall); end
    compared++; if (obs_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL load_hit_rdata got %h want deadbeef", obs_rdata); end
    compared++; if (dut.r_dirty[0] !== 1'b1) begin mismatched++; $display("FAIL store_hit_dirty got %b want 1", dut.r_dirty[0]); end
  endtask

  task automatic test_dirty_evict();
    predict(1, 0, 32'h504, 32'd0);
    run_access(1, 0, 32'h504, 32'd0, 0);
    compared++;
    if (q_addr.size() != 2 * WORDS) begin
      mismatched++; $display("FAIL evict_words got %0d want %0d", q_addr.size(), 2 * WORDS);
    end else begin
      for (int i = 0; i < 2 * WORDS; i++) begin
        compared++;
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i] || (e_we[i] && q_wdata[i] !== e_wdata[i])) begin
          mismatched++;
          $display("FAIL evict_xfer[%0d] got a=%h we=%b d=%h want a=%h we=%b d=%h",
                   i, q_addr[i], q_we[i], q_wdata[i], e_addr[i], e_we[i], e_wdata[i]);
        end
      end
      compared++; if (q_wdata[1] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL evict_store_word got %h want deadbeef", q_wdata[1]); end
    end
    compared++; if (obs_rdata !== e_rdata) begin mismatched++; $display("FAIL evict_rdata got %h want %h", obs_rdata, e_rdata); end
    compared++; if (obs_stall != 2 * WORDS + 1) begin mismatched++; $display("FAIL evict_stall got %0d want %0d", obs_stall, 2 * WORDS + 1); end
  endtask

  task automatic test_both_ce();
    @(negedge clk);
    mem_read_ce = 1'b1; mem_write_ce = 1'b1; addr = 32'h7F0; wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (dram_cache_miss !== 1'b0 || dram_req !== 1'b0) begin
        mismatched++; $display("FAIL both_ce cycle %0d got miss=%b req=%b want 0 0", i, dram_cache_miss, dram_req);
      end
      @(negedge clk);
    end
    mem_read_ce = 1'b0; mem_write_ce = 1'b0;
    predict(1, 0, 32'h7F0, 32'd0);
    run_access(1, 0, 32'h7F0, 32'd0, 0);
    compared++; if (q_addr.size() != WORDS) begin mismatched++; $display("FAIL both_ce_no_alloc got %0d words want %0d", q_addr.size(), WORDS); end
    compared++; if (obs_rdata !== e_rdata) begin mismatched++; $display("FAIL both_ce_rdata got %h want %h", obs_rdata, e_rdata); end
  endtask

  task automatic test_slow_ack();
    predict(1, 0, 32'h2A8, 32'd0);
    run_access(1, 0, 32'h2A8, 32'd0, 5);
    compared++; if (obs_stall != WORDS * 6 + 1) begin mismatched++; $display("FAIL slow_stall got %0d want %0d", obs_stall, WORDS * 6 + 1); end
    compared++; if (obs_unstable != 0) begin mismatched++; $display("FAIL slow_stable got %0d changes want 0", obs_unstable); end
    compared++; if (obs_rdata !== e_rdata) begin mismatched++; $display("FAIL slow_rdata got %h want %h", obs_rdata, e_rdata); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    seen = 0;
    @(negedge clk);
    mem_read_ce = 1'b1; addr = 32'h340; dram_ack = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      #1;
      if (dram_req && dram_addr == 32'h348) begin
        seen = 1;
      end else begin
        if (dram_req) begin dram_rdata = dram_word(dram_addr); dram_ack = 1'b1; end
        @(negedge clk);
        dram_ack = 1'b0;
      end
    end
    compared++; if (!seen) begin mismatched++; $display("FAIL midfill_reach got none want word 00000348"); end
    #2 rst = 1'b1;
    #1;
    compared++; if (dram_req !== 1'b0)        begin mismatched++; $display("FAIL midfill_req got %b want 0", dram_req); end
    compared++; if (dram_cache_miss !== 1'b0) begin mismatched++; $display("FAIL midfill_miss got %b want 0", dram_cache_miss); end
    @(negedge clk);
    rst = 1'b0; mem_read_ce = 1'b0;
    model_reset();
    predict(1, 0, 32'h344, 32'd0);
    run_access(1, 0, 32'h344, 32'd0, 0);
    compared++;
    if (q_addr.size() != WORDS || q_addr[0] !== 32'h340 || q_addr[WORDS-1] !== 32'h34C) begin
      mismatched++; $display("FAIL midfill_refill got %0d words first %h want %0d from 00000340", q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'd0, WORDS);
    end
    compared++; if (obs_rdata !== e_rdata) begin mismatched++; $display("FAIL midfill_rdata got %h want %h", obs_rdata, e_rdata); end
    // The line resident before the reset must now miss too.
    predict(1, 0, 32'h504, 32'd0);
    run_access(1, 0, 32'h504, 32'd0, 0);
    compared++; if (q_addr.size() != WORDS) begin mismatched++; $display("FAIL midfill_inval got %0d words want %0d", q_addr.size(), WORDS); end
  endtask

  task automatic test_random();
    bit          rd, wr;
    logic [31:0] a, wd;
    int          d, exp_stall, sel;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      a   = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      wd  = $urandom;
      d   = int'($urandom_range(0, 2));
      predict(rd, wr, a, wd);
      exp_stall = e_miss ? 1 + e_addr.size() * (d + 1) : 0;
      run_access(rd, wr, a, wd, d);
      compared++;
      if (obs_stall != exp_stall || q_addr.size() != e_addr.size()) begin
        mismatched++;
        $display("FAIL rand[%0d] a=%h rd=%b wr=%b got stall=%0d words=%0d want stall=%0d words=%0d",
                 n, a, rd, wr, obs_stall, q_addr.size(), exp_stall, e_addr.size());
      end else begin
        for (int i = 0; i < e_addr.size(); i++) begin
          compared++;
          if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i] || (e_we[i] && q_wdata[i] !== e_wdata[i])) begin
            mismatched++;
            $display("FAIL rand[%0d] xfer[%0d] got a=%h we=%b d=%h want a=%h we=%b d=%h",
                     n, i, q_addr[i], q_we[i], q_wdata[i], e_addr[i], e_we[i], e_wdata[i]);
          end
        end
      end
      if (rd && !wr) begin
        compared++;
        if (obs_rdata !== e_rdata) begin
          mismatched++; $display("FAIL rand[%0d] rdata a=%h got %h want %h", n, a, obs_rdata, e_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fill();
    test_store_hit();
    test_dirty_evict();
    test_both_ce();
    test_slow_ack();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
